// File: rtl/px_router_pkg.sv
// -----------------------------------------------------------------------------
// px_router_pkg
// Shared types and helpers for the pixel-stream channel router.
//   router_state_t : router FSM states (IDLE / ACTIVE / DRAIN)
//   cnt_width()    : bits needed to hold a count from 0 up to max_val inclusive
//                    (used for the select width and the FIFO level width)
//   bypass_sel()   : lowest select code that means bypass; any code at or
//                    above it routes straight into the output FIFO
// -----------------------------------------------------------------------------
package px_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } router_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int bypass_sel(input int n_ch);
        return n_ch;
    endfunction

endpackage

// File: rtl/px_sync_fifo.sv
// -----------------------------------------------------------------------------
// px_sync_fifo
// Single-clock pixel FIFO with a level output. The caller guarantees it never
// pushes into a full FIFO without a simultaneous pop, so no overflow guard.
// Ports:
//   i_clk, i_nreset : clock, asynchronous active-low reset
//   i_push, i_push_px : write strobe and data
//   i_pop            : read strobe (head advances)
//   o_head_px        : data at the head (valid while o_level != 0)
//   o_level          : current occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module px_sync_fifo
    import px_router_pkg::*;
#(
    parameter  int PX_W       = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = cnt_width(FIFO_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_nreset,
    input  logic              i_push,
    input  logic [PX_W-1:0]   i_push_px,
    input  logic              i_pop,
    output logic [PX_W-1:0]   o_head_px,
    output logic [LVL_W-1:0]  o_level
);

    logic [PX_W-1:0]   r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0]  r_level;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_px;
    end

    assign o_head_px = r_mem[r_rd_ptr];
    assign o_level   = r_level;

endmodule

// File: rtl/px_channel_router.sv
// -----------------------------------------------------------------------------
// px_channel_router
// Routes SPI pixels to one of N_CH processing channels (or bypasses them),
// collects channel results into an output FIFO and paces them back to SPI.
// Credit flow control keeps outstanding + FIFO level <= FIFO_DEPTH.
// Optional watchdog: define PX_ROUTER_TIMEOUT_EN.
// Ports:
//   clk_i, nreset_i        : clock, asynchronous active-low reset
//   sel_i                  : requested channel (>= N_CH means bypass)
//   clr_i                  : clears drop_o, timeout_o, px_count_o
//   in_rdy_i, in_px_i      : input pixel strobe and data
//   ch_rdy_o, ch_px_o      : one-hot strobe and pixel to the channels
//   ch_rdy_i, ch_px_i      : per-channel result strobes and packed results
//   out_busy_i             : SPI return path stall
//   out_rdy_o, out_px_o    : output pixel strobe and data
//   active_ch_o            : latched selection
//   fifo_level_o           : output FIFO occupancy
//   px_count_o             : pixels delivered (wraps)
//   drop_o, timeout_o      : sticky status flags
//   busy_o                 : FSM not in IDLE
// -----------------------------------------------------------------------------
module px_channel_router
    import px_router_pkg::*;
#(
    parameter  int PX_W        = 8,
    parameter  int N_CH        = 3,
    parameter  int FIFO_DEPTH  = 4,
    parameter  int CNT_W       = 16,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int SEL_W       = cnt_width(N_CH),
    localparam int LVL_W       = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  clr_i,
    input  logic                  in_rdy_i,
    input  logic [PX_W-1:0]       in_px_i,
    output logic [N_CH-1:0]       ch_rdy_o,
    output logic [PX_W-1:0]       ch_px_o,
    input  logic [N_CH-1:0]       ch_rdy_i,
    input  logic [N_CH*PX_W-1:0]  ch_px_i,
    input  logic                  out_busy_i,
    output logic                  out_rdy_o,
    output logic [PX_W-1:0]       out_px_o,
    output logic [SEL_W-1:0]      active_ch_o,
    output logic [LVL_W-1:0]      fifo_level_o,
    output logic [CNT_W-1:0]      px_count_o,
    output logic                  drop_o,
    output logic                  timeout_o,
    output logic                  busy_o
);

    router_state_t     r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_active_ch;
    logic [LVL_W-1:0]  r_outstanding;
    logic [N_CH-1:0]   r_ch_rdy_p1;
    logic [PX_W-1:0]   r_ch_px_p1;
    logic              r_out_vld_p1;
    logic [PX_W-1:0]   r_out_px_p1;
    logic [CNT_W-1:0]  r_px_count;
    logic              r_drop;

    logic [SEL_W-1:0]  w_route_ch;
    logic              w_route_byp;
    logic              w_credit_ok;
    logic              w_accept, w_accept_ch, w_accept_byp, w_drop_evt;
    logic              w_resp_vld;
    logic [PX_W-1:0]   w_resp_px;
    logic [N_CH-1:0]   w_ch_hot;
    logic              w_push, w_pop, w_quiet, w_wd_fire;
    logic [PX_W-1:0]   w_push_px, w_head_px;
    logic [LVL_W-1:0]  w_level;

    // In IDLE the selection is being latched this cycle, so an input arriving
    // now already follows sel_i rather than the stale latched value.
    assign w_route_ch   = (r_state == ST_IDLE) ? sel_i : r_active_ch;
    assign w_route_byp  = int'(w_route_ch) >= bypass_sel(N_CH);
    assign w_credit_ok  = ({1'b0, r_outstanding} + {1'b0, w_level}) < (LVL_W+1)'(FIFO_DEPTH);
    assign w_accept     = in_rdy_i && (r_state != ST_DRAIN) && w_credit_ok;
    assign w_accept_ch  = w_accept && !w_route_byp;
    assign w_accept_byp = w_accept && w_route_byp;
    assign w_drop_evt   = in_rdy_i && !w_accept;

    // Only the latched channel may answer, and only while it owes a result.
    always_comb begin
        w_resp_vld = 1'b0;
        w_resp_px  = '0;
        w_ch_hot   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_active_ch == SEL_W'(k)) begin
                w_resp_vld = ch_rdy_i[k] && (r_outstanding != '0);
                w_resp_px  = ch_px_i[k*PX_W +: PX_W];
            end
            w_ch_hot[k] = w_accept_ch && (w_route_ch == SEL_W'(k));
        end
    end

    // Bypass pushes and channel responses are mutually exclusive by mode.
    assign w_push    = w_accept_byp || w_resp_vld;
    assign w_push_px = w_accept_byp ? in_px_i : w_resp_px;
    assign w_pop     = (w_level != '0) && !out_busy_i && !r_out_vld_p1;
    assign w_quiet   = (r_outstanding == '0) && (w_level == '0) && !w_accept;

    px_sync_fifo #(
        .PX_W       (PX_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk_i),
        .i_nreset   (nreset_i),
        .i_push     (w_push),
        .i_push_px  (w_push_px),
        .i_pop      (w_pop),
        .o_head_px  (w_head_px),
        .o_level    (w_level)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (sel_i != r_active_ch) w_state_nxt = ST_DRAIN;
                else if (w_quiet)         w_state_nxt = ST_IDLE;
            end
            ST_DRAIN:  if (w_quiet) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        // Watchdog abandons the credits; anything already queued still drains.
        if (w_wd_fire) w_state_nxt = (w_level == '0) ? ST_IDLE : ST_DRAIN;
    end

    // ---- stage p1: routing strobes, output pacing, status ----
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state       <= ST_IDLE;
            r_active_ch   <= '0;
            r_outstanding <= '0;
            r_ch_rdy_p1   <= '0;
            r_ch_px_p1    <= '0;
            r_out_vld_p1  <= 1'b0;
            r_out_px_p1   <= '0;
            r_px_count    <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) r_active_ch <= sel_i;
            if (w_wd_fire) r_outstanding <= '0;
            else           r_outstanding <= r_outstanding + LVL_W'(w_accept_ch) - LVL_W'(w_resp_vld);
            r_ch_rdy_p1 <= w_ch_hot;
            if (w_accept_ch) r_ch_px_p1 <= in_px_i;
            r_out_vld_p1 <= w_pop;
            if (w_pop) r_out_px_p1 <= w_head_px;
            // A counting/flag event in the same cycle as clr_i takes priority.
            if (w_pop)      r_px_count <= clr_i ? CNT_W'(1) : r_px_count + CNT_W'(1);
            else if (clr_i) r_px_count <= '0;
            if (w_drop_evt) r_drop <= 1'b1;
            else if (clr_i) r_drop <= 1'b0;
        end
    end

`ifdef PX_ROUTER_TIMEOUT_EN
    localparam int WD_W = cnt_width(TIMEOUT_CYC);
    logic [WD_W-1:0] r_wd;
    logic            r_timeout;

    // Counts cycles with credits owed and no valid response arriving.
    assign w_wd_fire = (r_outstanding != '0) && !w_resp_vld && (r_wd == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_outstanding == '0) || w_resp_vld || w_wd_fire) r_wd <= '0;
            else                                                  r_wd <= r_wd + WD_W'(1);
            if (w_wd_fire)  r_timeout <= 1'b1;
            else if (clr_i) r_timeout <= 1'b0;
        end
    end

    assign timeout_o = r_timeout;
`else
    // Never fires: constant 0 for any legal (non-negative) TIMEOUT_CYC.
    assign w_wd_fire = (TIMEOUT_CYC < 0);
    assign timeout_o = 1'b0;
`endif

    assign ch_rdy_o     = r_ch_rdy_p1;
    assign ch_px_o      = r_ch_px_p1;
    assign out_rdy_o    = r_out_vld_p1;
    assign out_px_o     = r_out_px_p1;
    assign active_ch_o  = r_active_ch;
    assign fifo_level_o = w_level;
    assign px_count_o   = r_px_count;
    assign drop_o       = r_drop;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_px_channel_router.sv
module tb_px_channel_router;

    localparam int PX_W        = 8;
    localparam int N_CH        = 3;
    localparam int FIFO_DEPTH  = 4;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT_CYC = 16;

    logic                 clk = 1'b0;
    logic                 nreset_i;
    logic [1:0]           sel_i;
    logic                 clr_i;
    logic                 in_rdy_i;
    logic [PX_W-1:0]      in_px_i;
    logic [N_CH-1:0]      ch_rdy_o;
    logic [PX_W-1:0]      ch_px_o;
    logic [N_CH-1:0]      ch_rdy_i;
    logic [N_CH*PX_W-1:0] ch_px_i;
    logic                 out_busy_i;
    logic                 out_rdy_o;
    logic [PX_W-1:0]      out_px_o;
    logic [1:0]           active_ch_o;
    logic [2:0]           fifo_level_o;
    logic [CNT_W-1:0]     px_count_o;
    logic                 drop_o;
    logic                 timeout_o;
    logic                 busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    px_channel_router #(
        .PX_W        (PX_W),
        .N_CH        (N_CH),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i        (clk),
        .nreset_i     (nreset_i),
        .sel_i        (sel_i),
        .clr_i        (clr_i),
        .in_rdy_i     (in_rdy_i),
        .in_px_i      (in_px_i),
        .ch_rdy_o     (ch_rdy_o),
        .ch_px_o      (ch_px_o),
        .ch_rdy_i     (ch_rdy_i),
        .ch_px_i      (ch_px_i),
        .out_busy_i   (out_busy_i),
        .out_rdy_o    (out_rdy_o),
        .out_px_o     (out_px_o),
        .active_ch_o  (active_ch_o),
        .fifo_level_o (fifo_level_o),
        .px_count_o   (px_count_o),
        .drop_o       (drop_o),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        nreset_i = 1'b0; sel_i = 2'd0; clr_i = 1'b0; in_rdy_i = 1'b0; in_px_i = '0;
        ch_rdy_i = '0; ch_px_i = '0; out_busy_i = 1'b0;
        repeat (3) tick();
        total++;
        if ({ch_rdy_o, ch_px_o, out_rdy_o, out_px_o, active_ch_o, fifo_level_o,
             px_count_o, drop_o, timeout_o, busy_o} !== '0)
            begin bad++; $display("FAIL reset_outputs: got ch_rdy=%b out_rdy=%b lvl=%0d cnt=%0d drop=%b busy=%b want all 0",
                                  ch_rdy_o, out_rdy_o, fifo_level_o, px_count_o, drop_o, busy_o); end
        nreset_i = 1'b1;
        tick(); tick();
        total++;
        if (busy_o !== 1'b0 || fifo_level_o !== 3'd0)
            begin bad++; $display("FAIL idle_after_reset: got busy=%b lvl=%0d want 0 0", busy_o, fifo_level_o); end
    endtask

    task automatic test_bypass;
        bit ok;
        sel_i = 2'd3;
        tick(); tick();
        total++;
        if (active_ch_o !== 2'd3) begin bad++; $display("FAIL byp_active: got %0d want 3", active_ch_o); end
        in_rdy_i = 1'b1; in_px_i = 8'h5A;
        tick();
        in_rdy_i = 1'b0;
        total++;
        if (ch_rdy_o !== 3'b000 || fifo_level_o !== 3'd1 || out_rdy_o !== 1'b0)
            begin bad++; $display("FAIL byp_t1: got ch_rdy=%b lvl=%0d out_rdy=%b want 000 1 0", ch_rdy_o, fifo_level_o, out_rdy_o); end
        tick();
        total++;
        if (out_rdy_o !== 1'b1 || out_px_o !== 8'h5A)
            begin bad++; $display("FAIL byp_out: got rdy=%b px=%h want 1 5a", out_rdy_o, out_px_o); end
        total++;
        if (px_count_o !== 16'd1) begin bad++; $display("FAIL byp_count: got %0d want 1", px_count_o); end
        tick();
        total++;
        if (out_rdy_o !== 1'b0 || ch_rdy_o !== 3'b000)
            begin bad++; $display("FAIL byp_pulse_end: got out_rdy=%b ch_rdy=%b want 0 000", out_rdy_o, ch_rdy_o); end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL byp_idle: got busy=%b want 0", busy_o); end
    endtask

    task automatic test_channel;
        bit ok;
        sel_i = 2'd1;
        tick(); tick();
        in_rdy_i = 1'b1; in_px_i = 8'h10;
        tick();
        in_rdy_i = 1'b0;
        total++;
        if (ch_rdy_o !== 3'b010 || ch_px_o !== 8'h10)
            begin bad++; $display("FAIL ch_issue: got ch_rdy=%b px=%h want 010 10", ch_rdy_o, ch_px_o); end
        ch_rdy_i = 3'b001; ch_px_i = {8'h00, 8'h00, 8'h77};
        tick();
        ch_rdy_i = 3'b000;
        total++;
        if (fifo_level_o !== 3'd0 || ch_rdy_o !== 3'b000 || busy_o !== 1'b1)
            begin bad++; $display("FAIL ch_stray: got lvl=%0d ch_rdy=%b busy=%b want 0 000 1", fifo_level_o, ch_rdy_o, busy_o); end
        ch_rdy_i = 3'b010; ch_px_i = {8'h00, 8'hEF, 8'h00};
        tick();
        ch_rdy_i = 3'b000;
        total++;
        if (fifo_level_o !== 3'd1 || out_rdy_o !== 1'b0)
            begin bad++; $display("FAIL ch_resp_push: got lvl=%0d out_rdy=%b want 1 0", fifo_level_o, out_rdy_o); end
        tick();
        total++;
        if (out_rdy_o !== 1'b1 || out_px_o !== 8'hEF || px_count_o !== 16'd2)
            begin bad++; $display("FAIL ch_out: got rdy=%b px=%h cnt=%0d want 1 ef 2", out_rdy_o, out_px_o, px_count_o); end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ch_idle: got busy=%b want 0", busy_o); end
    endtask

    task automatic test_credit;
        bit ok;
        int n_out;
        int last_c;
        logic [7:0] got [4];
        sel_i = 2'd3;
        tick();
        out_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_rdy_i = 1'b1; in_px_i = 8'hA0 + 8'(i);
            tick();
        end
        in_rdy_i = 1'b0;
        total++;
        if (fifo_level_o !== 3'd4 || drop_o !== 1'b1 || out_rdy_o !== 1'b0)
            begin bad++; $display("FAIL credit_full: got lvl=%0d drop=%b out_rdy=%b want 4 1 0", fifo_level_o, drop_o, out_rdy_o); end
        out_busy_i = 1'b0;
        n_out = 0; last_c = -10;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (out_rdy_o === 1'b1) begin
                total++;
                if (c - last_c < 2) begin bad++; $display("FAIL credit_spacing: got gap %0d want >=2", c - last_c); end
                last_c = c;
                if (n_out < 4) got[n_out] = out_px_o;
                n_out++;
            end
        end
        total++;
        if (n_out != 4) begin bad++; $display("FAIL credit_count: got %0d pulses want 4", n_out); end
        for (int k = 0; k < 4 && k < n_out; k++) begin
            total++;
            if (got[k] !== 8'hA0 + 8'(k)) begin bad++; $display("FAIL credit_order: got %h want %h", got[k], 8'hA0 + 8'(k)); end
        end
        wait_idle(ok);
        total++;
        if (!ok || px_count_o !== 16'd6)
            begin bad++; $display("FAIL credit_end: got busy=%b cnt=%0d want 0 6", busy_o, px_count_o); end
    endtask

    task automatic test_sticky;
        bit ok;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        total++;
        if (drop_o !== 1'b0 || px_count_o !== 16'd0)
            begin bad++; $display("FAIL clr_alone: got drop=%b cnt=%0d want 0 0", drop_o, px_count_o); end
        out_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_rdy_i = 1'b1; in_px_i = 8'hB0 + 8'(i);
            clr_i = (i == 4);
            tick();
        end
        in_rdy_i = 1'b0; clr_i = 1'b0;
        total++;
        if (drop_o !== 1'b1 || fifo_level_o !== 3'd4)
            begin bad++; $display("FAIL clr_vs_drop: got drop=%b lvl=%0d want 1 4", drop_o, fifo_level_o); end
        out_busy_i = 1'b0; clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        total++;
        if (px_count_o !== 16'd1 || drop_o !== 1'b0 || out_rdy_o !== 1'b1 || out_px_o !== 8'hB0)
            begin bad++; $display("FAIL clr_vs_count: got cnt=%0d drop=%b rdy=%b px=%h want 1 0 1 b0",
                                  px_count_o, drop_o, out_rdy_o, out_px_o); end
        wait_idle(ok);
        total++;
        if (!ok || px_count_o !== 16'd4)
            begin bad++; $display("FAIL sticky_end: got busy=%b cnt=%0d want 0 4", busy_o, px_count_o); end
    endtask

    task automatic test_switch;
        int n_out;
        logic [7:0] got [4];
        sel_i = 2'd0;
        tick(); tick();
        in_rdy_i = 1'b1; in_px_i = 8'h01;
        tick();
        in_px_i = 8'h02;
        tick();
        in_rdy_i = 1'b0;
        total++;
        if (ch_rdy_o !== 3'b001 || ch_px_o !== 8'h02)
            begin bad++; $display("FAIL sw_issue: got ch_rdy=%b px=%h want 001 02", ch_rdy_o, ch_px_o); end
        sel_i = 2'd2;
        tick();
        total++;
        if (busy_o !== 1'b1 || active_ch_o !== 2'd0 || drop_o !== 1'b0)
            begin bad++; $display("FAIL sw_drain: got busy=%b act=%0d drop=%b want 1 0 0", busy_o, active_ch_o, drop_o); end
        in_rdy_i = 1'b1; in_px_i = 8'h33;
        tick();
        in_rdy_i = 1'b0;
        total++;
        if (drop_o !== 1'b1 || ch_rdy_o !== 3'b000 || fifo_level_o !== 3'd0)
            begin bad++; $display("FAIL sw_drop: got drop=%b ch_rdy=%b lvl=%0d want 1 000 0", drop_o, ch_rdy_o, fifo_level_o); end
        n_out = 0;
        for (int c = 0; c < 30; c++) begin
            ch_rdy_i = (c < 2) ? 3'b001 : 3'b000;
            ch_px_i  = {16'h0000, (c == 0) ? 8'hC1 : 8'hC2};
            tick();
            if (out_rdy_o === 1'b1) begin
                if (n_out < 4) got[n_out] = out_px_o;
                n_out++;
            end
            if (c >= 2 && busy_o === 1'b0) break;
        end
        ch_rdy_i = 3'b000;
        total++;
        if (busy_o !== 1'b0 || n_out != 2)
            begin bad++; $display("FAIL sw_idle: got busy=%b outs=%0d want 0 2", busy_o, n_out); end
        total++;
        if (n_out >= 2 && (got[0] !== 8'hC1 || got[1] !== 8'hC2))
            begin bad++; $display("FAIL sw_data: got %h %h want c1 c2", got[0], got[1]); end
        tick();
        total++;
        if (active_ch_o !== 2'd2) begin bad++; $display("FAIL sw_newsel: got %0d want 2", active_ch_o); end
    endtask

    task automatic test_timeout;
        bit ok;
        int fired;
        sel_i = 2'd1;
        tick(); tick();
        in_rdy_i = 1'b1; in_px_i = 8'h44;
        tick();
        in_rdy_i = 1'b0;
`ifdef PX_ROUTER_TIMEOUT_EN
        fired = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (timeout_o === 1'b1) begin
                fired = c;
                break;
            end
        end
        total++;
        if (fired != 16) begin bad++; $display("FAIL to_cycle: got %0d want 16", fired); end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL to_idle: got busy=%b want 0", busy_o); end
        ok = 1'b1;
`else
        fired = 0;
        repeat (40) tick();
        total++;
        if (timeout_o !== 1'b0 || busy_o !== 1'b1)
            begin bad++; $display("FAIL no_to: got timeout=%b busy=%b want 0 1", timeout_o, busy_o); end
        ch_rdy_i = 3'b010; ch_px_i = {8'h00, 8'h45, 8'h00};
        tick();
        ch_rdy_i = 3'b000;
        wait_idle(ok);
`endif
        total++;
        if (!ok || fired < 0) begin bad++; $display("FAIL to_end: got busy=%b want 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_channel();
        test_credit();
        test_sticky();
        test_switch();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
